// File: rtl/dm_abs_cmd.sv
// Debug Module abstract-command executor: decodes Access Register commands and
// performs the GPR/CSR access on the halted core over the req/ack register port.
module dm_abs_cmd #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [DATA_WIDTH-1:0] command,
    input  logic [DATA_WIDTH-1:0] data0,
    input  logic                  cmd_update,
    input  logic                  cmderr_clr,
    input  logic                  core_halted,
    output logic                  cmd_finished,
    output logic                  cmd_read_data_valid,
    output logic [DATA_WIDTH-1:0] cmd_read_data,
    output logic                  busy,
    output logic [2:0]            cmderr,
    output logic                  dbg_reg_req,
    output logic                  dbg_reg_is_csr,
    output logic [11:0]           dbg_reg_addr,
    output logic                  dbg_reg_wr,
    output logic [DATA_WIDTH-1:0] dbg_reg_wdata,
    input  logic                  dbg_reg_ack,
    input  logic                  dbg_reg_err,
    input  logic [DATA_WIDTH-1:0] dbg_reg_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_ACCESS,
        S_DONE
    } state_t;

    localparam logic [2:0] ERR_BUSY        = 3'd1;
    localparam logic [2:0] ERR_UNSUPPORTED = 3'd2;
    localparam logic [2:0] ERR_EXCEPTION   = 3'd3;
    localparam logic [2:0] ERR_HALTRESUME  = 3'd4;
    localparam logic [7:0] TMO_LAST        = 8'(TIMEOUT_CYCLES - 1);

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] cmd_q;
    logic [DATA_WIDTH-1:0] data0_q;
    logic [7:0]            cnt;
    logic                  read_ok;
    logic                  start_access;
    logic                  fsm_err;
    logic [2:0]            fsm_code;
    logic                  err_set;
    logic [2:0]            err_code;
    logic                  unused_cmd_bit;

    logic [7:0]  f_cmdtype;
    logic [2:0]  f_aarsize;
    logic        f_postinc;
    logic        f_postexec;
    logic        f_transfer;
    logic        f_write;
    logic [15:0] f_regno;
    logic        unsupported;

    assign f_cmdtype      = cmd_q[31:24];
    assign unused_cmd_bit = cmd_q[23];
    assign f_aarsize      = cmd_q[22:20];
    assign f_postinc      = cmd_q[19];
    assign f_postexec     = cmd_q[18];
    assign f_transfer     = cmd_q[17];
    assign f_write        = cmd_q[16];
    assign f_regno        = cmd_q[15:0];

    // Legal transfer targets: CSRs 0x000-0xFFF and GPRs 0x1000-0x101F.
    assign unsupported = (f_cmdtype != 8'd0) || f_postinc || f_postexec ||
                         (f_transfer && ((f_aarsize != 3'd2) || (f_regno > 16'h101F)));

    assign busy                = (state != S_IDLE);
    assign dbg_reg_req         = (state == S_ACCESS);
    assign cmd_finished        = (state == S_DONE);
    assign cmd_read_data_valid = (state == S_DONE) && read_ok;

    always_comb begin
        state_nxt    = state;
        start_access = 1'b0;
        fsm_err      = 1'b0;
        fsm_code     = '0;
        unique case (state)
            S_IDLE: begin
                if (cmd_update) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                state_nxt = S_DONE;
                if (cmderr != 3'd0) begin
                    state_nxt = S_DONE;
                end else if (!core_halted) begin
                    fsm_err  = 1'b1;
                    fsm_code = ERR_HALTRESUME;
                end else if (unsupported) begin
                    fsm_err  = 1'b1;
                    fsm_code = ERR_UNSUPPORTED;
                end else if (f_transfer) begin
                    state_nxt    = S_ACCESS;
                    start_access = 1'b1;
                end
            end
            S_ACCESS: begin
                if (dbg_reg_ack) begin
                    state_nxt = S_DONE;
                    fsm_err   = dbg_reg_err;
                    fsm_code  = ERR_EXCEPTION;
                end else if (cnt == TMO_LAST) begin
                    state_nxt = S_DONE;
                    fsm_err   = 1'b1;
                    fsm_code  = ERR_EXCEPTION;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // A command error from decode/access takes precedence over a busy collision.
    always_comb begin
        err_set  = 1'b0;
        err_code = '0;
        if (fsm_err) begin
            err_set  = 1'b1;
            err_code = fsm_code;
        end else if (cmd_update && (state != S_IDLE)) begin
            err_set  = 1'b1;
            err_code = ERR_BUSY;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state          <= S_IDLE;
            cmd_q          <= '0;
            data0_q        <= '0;
            cnt            <= '0;
            read_ok        <= 1'b0;
            cmderr         <= '0;
            cmd_read_data  <= '0;
            dbg_reg_is_csr <= 1'b0;
            dbg_reg_addr   <= '0;
            dbg_reg_wr     <= 1'b0;
            dbg_reg_wdata  <= '0;
        end else begin
            state <= state_nxt;
            if ((state == S_IDLE) && cmd_update) begin
                cmd_q   <= command;
                data0_q <= data0;
            end
            if (state == S_DECODE) begin
                cnt     <= '0;
                read_ok <= 1'b0;
            end
            if (start_access) begin
                dbg_reg_is_csr <= (f_regno < 16'h1000);
                dbg_reg_addr   <= (f_regno < 16'h1000) ? f_regno[11:0] : {7'b0, f_regno[4:0]};
                dbg_reg_wr     <= f_write;
                dbg_reg_wdata  <= data0_q;
            end
            if (state == S_ACCESS) begin
                cnt <= cnt + 8'd1;
                if (dbg_reg_ack && !dbg_reg_err && !dbg_reg_wr) begin
                    cmd_read_data <= dbg_reg_rdata;
                    read_ok       <= 1'b1;
                end
            end
            // Clear first so a simultaneous error set overrides it.
            if (cmderr_clr) cmderr <= '0;
            if (err_set && (cmderr == 3'd0)) cmderr <= err_code;
        end
    end

endmodule

// File: tb/tb_dm_abs_cmd.sv
// Randomized self-checking bench for dm_abs_cmd against a transaction-level
// model of command outcome, latency, access fields and cmderr stickiness.
module tb_dm_abs_cmd;

    localparam int TMO = 255;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [31:0] command = '0;
    logic [31:0] data0 = '0;
    logic        cmd_update = 1'b0;
    logic        cmderr_clr = 1'b0;
    logic        core_halted = 1'b0;
    logic        cmd_finished;
    logic        cmd_read_data_valid;
    logic [31:0] cmd_read_data;
    logic        busy;
    logic [2:0]  cmderr;
    logic        dbg_reg_req;
    logic        dbg_reg_is_csr;
    logic [11:0] dbg_reg_addr;
    logic        dbg_reg_wr;
    logic [31:0] dbg_reg_wdata;
    logic        dbg_reg_ack = 1'b0;
    logic        dbg_reg_err = 1'b0;
    logic [31:0] dbg_reg_rdata = '0;

    int n_checks = 0;
    int n_errors = 0;
    logic [2:0]  model_cmderr = '0;
    logic [31:0] model_rdata = '0;

    dm_abs_cmd #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .command(command), .data0(data0),
        .cmd_update(cmd_update), .cmderr_clr(cmderr_clr), .core_halted(core_halted),
        .cmd_finished(cmd_finished), .cmd_read_data_valid(cmd_read_data_valid),
        .cmd_read_data(cmd_read_data), .busy(busy), .cmderr(cmderr),
        .dbg_reg_req(dbg_reg_req), .dbg_reg_is_csr(dbg_reg_is_csr),
        .dbg_reg_addr(dbg_reg_addr), .dbg_reg_wr(dbg_reg_wr),
        .dbg_reg_wdata(dbg_reg_wdata), .dbg_reg_ack(dbg_reg_ack),
        .dbg_reg_err(dbg_reg_err), .dbg_reg_rdata(dbg_reg_rdata)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // d < 0 means the core never acks; poke issues a second command mid-access.
    task automatic run_cmd(input logic [31:0] cmd, input logic [31:0] d0, input logic halted,
                           input int d, input logic aerr, input logic [31:0] rd, input logic poke);
        int unsigned ctype, asz, regno;
        logic pi, pe, xf, wr, unsup, acc, exp_valid, exp_csr, poke_en, seen, fld_bad;
        logic [2:0]  e;
        logic [31:0] exp_addr, vdata;
        logic [31:0] f_csr, f_addr, f_wr, f_wdata;
        int exp_fin, exp_req, req_n, valid_n, fin_at;

        ctype = cmd >> 24;
        asz   = (cmd >> 20) & 7;
        pi    = ((cmd >> 19) & 1) != 0;
        pe    = ((cmd >> 18) & 1) != 0;
        xf    = ((cmd >> 17) & 1) != 0;
        wr    = ((cmd >> 16) & 1) != 0;
        regno = cmd & 32'hFFFF;
        unsup = (ctype != 0) || pi || pe || (xf && (asz != 2 || regno > 32'h101F));

        e = model_cmderr;
        acc = 1'b0;
        exp_valid = 1'b0;
        if (e != 0) acc = 1'b0;
        else if (!halted) e = 3'd4;
        else if (unsup) e = 3'd2;
        else if (xf) acc = 1'b1;

        poke_en = poke && acc && (d >= 1);
        if (poke_en) e = 3'd1;
        if (acc) begin
            if (d < 0 || aerr) begin
                if (e == 0) e = 3'd3;
            end else if (!wr) begin
                exp_valid = 1'b1;
            end
        end
        if (acc) begin
            exp_fin = (d < 0) ? 2 + TMO : 3 + d;
            exp_req = (d < 0) ? TMO : d + 1;
        end else begin
            exp_fin = 2;
            exp_req = 0;
        end
        exp_csr  = regno < 32'h1000;
        exp_addr = exp_csr ? (regno & 32'hFFF) : (regno & 32'h1F);

        @(negedge sys_clk);
        command = cmd; data0 = d0; core_halted = halted; cmd_update = 1'b1;
        req_n = 0; valid_n = 0; fin_at = -1; seen = 1'b0; fld_bad = 1'b0; vdata = '0;
        f_csr = '0; f_addr = '0; f_wr = '0; f_wdata = '0;
        for (int c = 1; c <= 300 && fin_at < 0; c++) begin
            @(negedge sys_clk);
            if (c == 1) check_eq("busy_decode", 32'(busy), 32'd1);
            if (dbg_reg_req) begin
                req_n++;
                if (!seen) begin
                    seen = 1'b1;
                    f_csr = 32'(dbg_reg_is_csr); f_addr = 32'(dbg_reg_addr);
                    f_wr = 32'(dbg_reg_wr); f_wdata = dbg_reg_wdata;
                end else if (f_csr != 32'(dbg_reg_is_csr) || f_addr != 32'(dbg_reg_addr) ||
                             f_wr != 32'(dbg_reg_wr) || f_wdata != dbg_reg_wdata) begin
                    fld_bad = 1'b1;
                end
            end
            if (cmd_read_data_valid) begin
                valid_n++;
                vdata = cmd_read_data;
            end
            if (cmd_finished) fin_at = c;
            cmd_update = poke_en && (c == 2);
            cmderr_clr = poke_en && (c == 2);
            if (poke_en && c == 2) command = 32'h0022_1001;
            // Rejected commands see a stray ack, which must be ignored.
            dbg_reg_ack   = acc ? (d >= 0 && c == 2 + d) : (c == 2);
            dbg_reg_err   = aerr;
            dbg_reg_rdata = dbg_reg_ack ? rd : $urandom;
        end
        dbg_reg_ack = 1'b0;
        dbg_reg_err = 1'b0;
        cmd_update  = 1'b0;
        cmderr_clr  = 1'b0;
        if (exp_valid) model_rdata = rd;

        check_eq("finish_cycle", 32'(fin_at), 32'(exp_fin));
        check_eq("req_cycles", 32'(req_n), 32'(exp_req));
        check_eq("read_valid_cnt", 32'(valid_n), exp_valid ? 32'd1 : 32'd0);
        if (exp_valid) check_eq("read_valid_data", vdata, rd);
        if (acc) begin
            check_eq("acc_is_csr", f_csr, 32'(exp_csr));
            check_eq("acc_addr", f_addr, exp_addr);
            check_eq("acc_wr", f_wr, 32'(wr));
            check_eq("acc_wdata", f_wdata, d0);
            check_eq("acc_stable", 32'(fld_bad), 32'd0);
        end
        @(negedge sys_clk);
        check_eq("busy_after", 32'(busy), 32'd0);
        check_eq("finished_once", 32'(cmd_finished), 32'd0);
        check_eq("cmderr_after", 32'(cmderr), 32'(e));
        check_eq("read_data_hold", cmd_read_data, model_rdata);
        model_cmderr = e;
    endtask

    task automatic clr_err();
        @(negedge sys_clk);
        cmderr_clr = 1'b1;
        @(negedge sys_clk);
        cmderr_clr = 1'b0;
        model_cmderr = '0;
        check_eq("cmderr_clr", 32'(cmderr), 32'd0);
    endtask

    task automatic reset_mid_access();
        int fin;
        @(negedge sys_clk);
        command = 32'h0022_1003; data0 = '0; core_halted = 1'b1; cmd_update = 1'b1;
        @(negedge sys_clk);
        cmd_update = 1'b0;
        @(negedge sys_clk);
        check_eq("rst_pre_req", 32'(dbg_reg_req), 32'd1);
        cmd_update = 1'b1;
        @(negedge sys_clk);
        cmd_update = 1'b0;
        check_eq("rst_pre_err", 32'(cmderr), 32'd1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        model_cmderr = '0;
        model_rdata = '0;
        check_eq("rst_req", 32'(dbg_reg_req), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_cmderr", 32'(cmderr), 32'd0);
        check_eq("rst_rdata", cmd_read_data, 32'd0);
        fin = 0;
        for (int i = 0; i < 5; i++) begin
            if (cmd_finished) fin++;
            @(negedge sys_clk);
        end
        check_eq("rst_no_finish", 32'(fin), 32'd0);
    endtask

    initial begin
        logic [7:0]  ctype;
        logic [2:0]  asz;
        logic        pi, pe, xf, wr;
        logic [15:0] rg;
        int cls, d;

        repeat (3) @(negedge sys_clk);
        check_eq("reset_rdata", cmd_read_data, 32'd0);
        check_eq("reset_cmderr", 32'(cmderr), 32'd0);
        check_eq("reset_addr", 32'(dbg_reg_addr), 32'd0);
        check_eq("reset_wdata", dbg_reg_wdata, 32'd0);
        check_eq("reset_outs", 32'({busy, dbg_reg_req, cmd_finished, cmd_read_data_valid,
                                    dbg_reg_is_csr, dbg_reg_wr}), 32'd0);
        sys_rst = 1'b0;

        run_cmd(32'h0022_1005, 32'h0, 1'b1, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);
        run_cmd(32'h0023_0341, 32'h1234_5678, 1'b1, 3, 1'b0, 32'h5555_AAAA, 1'b0);
        run_cmd(32'h0032_1000, 32'h0, 1'b1, 0, 1'b0, 32'h0, 1'b0);
        run_cmd(32'h0022_1005, 32'h0, 1'b1, 0, 1'b0, 32'h1111_2222, 1'b0);
        clr_err();
        run_cmd(32'h0022_1005, 32'h0, 1'b1, 1, 1'b0, 32'h0BAD_F00D, 1'b0);
        run_cmd(32'h0022_1006, 32'h0, 1'b0, 0, 1'b0, 32'h0, 1'b0);
        clr_err();
        run_cmd(32'h0022_0300, 32'h0, 1'b1, -1, 1'b0, 32'h0, 1'b0);
        clr_err();
        run_cmd(32'h0022_1007, 32'h0, 1'b1, 2, 1'b0, 32'hCAFE_0001, 1'b1);
        clr_err();
        run_cmd(32'h0022_0B00, 32'h0, 1'b1, 1, 1'b1, 32'h7777_7777, 1'b0);
        clr_err();
        run_cmd(32'h0022_1008, 32'h0, 1'b1, 254, 1'b0, 32'h0102_0304, 1'b0);
        reset_mid_access();

        for (int it = 0; it < 40; it++) begin
            if (model_cmderr != 0 && $urandom_range(0, 1) == 1) clr_err();
            ctype = '0; asz = 3'd2; pi = 1'b0; pe = 1'b0; xf = 1'b1;
            wr = 1'($urandom_range(0, 1));
            rg = 16'($urandom_range(32'h1000, 32'h101F));
            cls = $urandom_range(0, 9);
            case (cls)
                4, 5, 6: rg = 16'($urandom_range(0, 32'hFFF));
                7:       rg = 16'($urandom_range(32'h1020, 32'hFFFF));
                8: begin
                    xf = 1'b0;
                    rg = 16'($urandom);
                end
                9: case ($urandom_range(0, 3))
                    0:       asz = 3'($urandom_range(3, 7));
                    1:       pi = 1'b1;
                    2:       pe = 1'b1;
                    default: ctype = 8'($urandom_range(1, 255));
                endcase
                default: ;
            endcase
            d = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
            run_cmd({ctype, 1'b0, asz, pi, pe, xf, wr, rg}, $urandom,
                    $urandom_range(0, 9) != 0, d, $urandom_range(0, 4) == 0,
                    $urandom, $urandom_range(0, 5) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
